// File: rtl/big_bomb_scanner.sv
// Big-bomb scanner: walks the 3x3 neighbourhood of a target cell in raster order S0..S8 and
// reduces the board values to the largest ship size and a hit count. Optional hit_mask: BIG_BOMB_HITMASK_EN.
module big_bomb_scanner #(
  parameter int ROWS   = 10,
  parameter int COLS   = 10,
  parameter int CELL_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        row,
  input  logic [3:0]        col,
  output logic              ready,
  output logic              rd_en,
  output logic [3:0]        rd_row,
  output logic [3:0]        rd_col,
  input  logic [CELL_W-1:0] rd_data,
  output logic              done,
  output logic [CELL_W-1:0] biggest,
  output logic [3:0]        hit_count,
`ifdef BIG_BOMB_HITMASK_EN
  output logic [8:0]        hit_mask,
`endif
  output logic [1:0]        fsm_state
);

  // Handshake: a scan is accepted on a clock edge where start=1 and ready=1; start at any
  // other time is dropped. done is a one-cycle pulse; results hold until the next accept.

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic signed [4:0] ROWS_S = 5'(ROWS);
  localparam logic signed [4:0] COLS_S = 5'(COLS);

  state_t            state, state_nx;
  logic [3:0]        slot;
  logic [3:0]        row_q, col_q;
  logic              cap_pend;
  logic signed [4:0] dr, dc, cell_r, cell_c;
  logic              in_bounds;
`ifdef BIG_BOMB_HITMASK_EN
  logic [3:0]        cap_slot;
`endif

  assign fsm_state = state;

  // Slot k maps to offset (k/3-1, k%3-1); cell arithmetic is signed so edge targets fall out of bounds.
  always_comb begin
    dr = 5'sd0;
    dc = 5'sd0;
    case (slot)
      4'd0, 4'd1, 4'd2: dr = -5'sd1;
      4'd6, 4'd7, 4'd8: dr = 5'sd1;
      default:          dr = 5'sd0;
    endcase
    case (slot)
      4'd0, 4'd3, 4'd6: dc = -5'sd1;
      4'd2, 4'd5, 4'd8: dc = 5'sd1;
      default:          dc = 5'sd0;
    endcase
    cell_r    = $signed({1'b0, row_q}) + dr;
    cell_c    = $signed({1'b0, col_q}) + dc;
    in_bounds = (cell_r >= 5'sd0) && (cell_r < ROWS_S) &&
                (cell_c >= 5'sd0) && (cell_c < COLS_S);
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    rd_row   = 4'd0;
    rd_col   = 4'd0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = ISSUE;
      end
      ISSUE: begin
        if (in_bounds) begin
          rd_en  = 1'b1;
          rd_row = cell_r[3:0];
          rd_col = cell_c[3:0];
        end
        if (slot == 4'd8) state_nx = DRAIN;
      end
      DRAIN: state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      slot      <= 4'd0;
      row_q     <= 4'd0;
      col_q     <= 4'd0;
      cap_pend  <= 1'b0;
      biggest   <= '0;
      hit_count <= 4'd0;
`ifdef BIG_BOMB_HITMASK_EN
      cap_slot  <= 4'd0;
      hit_mask  <= 9'd0;
`endif
    end else begin
      state    <= state_nx;
      cap_pend <= rd_en;
`ifdef BIG_BOMB_HITMASK_EN
      cap_slot <= slot;
`endif
      if (state == IDLE && start) begin
        row_q     <= row;
        col_q     <= col;
        slot      <= 4'd0;
        biggest   <= '0;
        hit_count <= 4'd0;
`ifdef BIG_BOMB_HITMASK_EN
        hit_mask  <= 9'd0;
`endif
      end else if (state == ISSUE) begin
        slot <= slot + 4'd1;
      end
      // Strict compare keeps the earlier value on ties.
      if (cap_pend && rd_data != '0) begin
        if (rd_data > biggest) biggest <= rd_data;
        hit_count <= hit_count + 4'd1;
`ifdef BIG_BOMB_HITMASK_EN
        hit_mask[cap_slot] <= 1'b1;
`endif
      end
    end
  end

endmodule
